// File: rtl/ifetch_prefetch_queue_pkg.sv
// Shared CPU definitions for the instruction-fetch front end:
// word width, reset vector, NOP encoding and the queue entry layout.
package ifetch_prefetch_queue_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam word_t NOP_INSTR            = 32'h0000_0013;

  // One queue slot: the fetched word together with the address it came from.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } qentry_t;

  function automatic word_t word_align(input word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_prefetch_queue_chk.sv
// Protocol checks for the prefetch queue: a response must always find room,
// and a response must never arrive with no request outstanding.
module ifetch_prefetch_queue_chk (
  input logic clk,
  input logic rst_n,
  input logic push_req,
  input logic full,
  input logic resp_valid,
  input logic outst_zero
);

  a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_req && full));

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp_valid && outst_zero));

endmodule

// File: rtl/ifetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO of {pc, instr} entries with a single-cycle flush.
// Push on full and pop on empty are ignored; flush has priority over both.
module sync_fifo
  import ifetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  qentry_t                    push_data,
  input  logic                       pop,
  output qentry_t                    head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  qentry_t         mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            full_s;
  logic            do_push_s;
  logic            do_pop_s;

  // Qualify push/pop against occupancy and flush.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    do_push_s = push && !full_s && !flush;
    do_pop_s  = pop && (count_r != {CW{1'b0}}) && !flush;
  end

  // Storage write port; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Head and status views.
  always_comb begin
    head  = mem_r[rd_ptr_r];
    count = count_r;
    full  = full_s;
  end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches under a credit
// limit, tracks in-order responses and discards those made stale by a redirect.
module ifetch_prefetch_queue
  import ifetch_prefetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          DEPTH        = 4,
  parameter int          MAX_OUTST    = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int QCW = $clog2(DEPTH) + 1;
  localparam int OCW = $clog2(MAX_OUTST + 1);
  localparam int SW  = ((QCW > OCW) ? QCW : OCW) + 1;

  logic            run_r;
  word_t           fetch_pc_r;
  word_t           resp_pc_r;
  logic [OCW-1:0]  outst_r;
  logic [OCW-1:0]  discard_r;

  logic [QCW-1:0]  occ_s;
  logic            full_s;
  qentry_t         head_s;
  qentry_t         push_entry_s;
  logic            accept_s;
  logic            discard_now_s;
  logic            push_req_s;
  logic            push_s;
  logic            pop_s;
  logic [OCW-1:0]  outst_nxt_s;
  logic [OCW-1:0]  discard_nxt_s;

  // Fetch request: every queued word plus every in-flight request holds a slot.
  always_comb begin
    req_valid_o = run_r
               && ((SW'(occ_s) + SW'(outst_r)) < SW'(DEPTH))
               && (outst_r < OCW'(MAX_OUTST))
               && !redirect_i;
    req_addr_o  = fetch_pc_r;
    accept_s    = req_valid_o && req_ready_i;
  end

  // Response routing and credit/discard bookkeeping.
  always_comb begin
    discard_now_s = resp_valid_i && (discard_r != {OCW{1'b0}});
    push_req_s    = resp_valid_i && !discard_now_s && !redirect_i;
    push_s        = push_req_s && !full_s;
    pop_s         = instr_valid_o && instr_ready_i;
    outst_nxt_s   = outst_r + OCW'(accept_s) - OCW'(resp_valid_i);
    push_entry_s  = '{pc: resp_pc_r, instr: resp_data_i};
    // A redirect turns everything still in flight after this cycle into discards.
    if (redirect_i) begin
      discard_nxt_s = outst_nxt_s;
    end else begin
      discard_nxt_s = discard_r - OCW'(discard_now_s);
    end
  end

  // Fetch and response PC tracking; responses are in order so a counter suffices.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      run_r      <= 1'b0;
      fetch_pc_r <= RESET_VECTOR;
      resp_pc_r  <= RESET_VECTOR;
      outst_r    <= {OCW{1'b0}};
      discard_r  <= {OCW{1'b0}};
    end else begin
      run_r     <= 1'b1;
      outst_r   <= outst_nxt_s;
      discard_r <= discard_nxt_s;
      if (redirect_i) begin
        fetch_pc_r <= word_align(redirect_pc_i);
        resp_pc_r  <= word_align(redirect_pc_i);
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (push_req_s) begin
          resp_pc_r <= resp_pc_r + 32'd4;
        end
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk_i),
    .rst_n     (reset_i),
    .flush     (redirect_i),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (occ_s),
    .full      (full_s)
  );

  // Head view; zero while empty so a flushed slot never leaks out.
  always_comb begin
    instr_valid_o = (occ_s != {QCW{1'b0}});
    if (instr_valid_o) begin
      instr_o = head_s.instr;
      pc_o    = head_s.pc;
    end else begin
      instr_o = 32'h0000_0000;
      pc_o    = 32'h0000_0000;
    end
  end

  ifetch_prefetch_queue_chk u_chk (
    .clk        (clk_i),
    .rst_n      (reset_i),
    .push_req   (push_req_s),
    .full       (full_s),
    .resp_valid (resp_valid_i),
    .outst_zero (outst_r == {OCW{1'b0}})
  );

endmodule

// File: doc/ifetch_prefetch_queue.md
IFETCH_PREFETCH_QUEUE -- requirements
Module: ifetch_prefetch_queue

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, at least 2.
REQ-003 Parameter MAX_OUTST, default 2: maximum accepted-but-unanswered memory requests.
REQ-004 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset_i, input, 1: reset, asynchronous, active-low.
REQ-006 Port req_valid_o, output, 1: fetch request to instruction memory.
REQ-007 Port req_addr_o, output, 32: word-aligned fetch address.
REQ-008 Port req_ready_i, input, 1: memory accepts the request this cycle.
REQ-009 Port resp_valid_i, input, 1: instruction word returned; responses are in order.
REQ-010 Port resp_data_i, input, 32: returned instruction word.
REQ-011 Port instr_valid_o, output, 1: queue head is valid toward the fetch/decode register.
REQ-012 Port instr_o, output, 32: head instruction.
REQ-013 Port pc_o, output, 32: address of the head instruction.
REQ-014 Port instr_ready_i, input, 1: downstream consumes the head this cycle.
REQ-015 Port redirect_i, input, 1: taken branch or jump from the execute stage.
REQ-016 Port redirect_pc_i, input, 32: branch target.

Function
REQ-017 A request transfers when req_valid_o && req_ready_i; a pop occurs when instr_valid_o && instr_ready_i.
REQ-018 req_valid_o SHALL be 1 iff (occupancy + outstanding) < DEPTH, outstanding < MAX_OUTST, and redirect_i = 0.
REQ-019 req_valid_o and req_addr_o SHALL stay stable until accepted; they change early only on a redirect.
REQ-020 After each accepted request, fetch_pc SHALL advance by 4, wrapping modulo 2^32.
REQ-021 A non-discarded response SHALL be pushed with its PC (issue PC, tracked in order) and become visible on instr_o/pc_o the next cycle; there is no same-cycle bypass.
REQ-022 instr_o and pc_o SHALL always come from the head entry; instr_valid_o = (occupancy != 0).
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged; pop on empty and push on full are impossible by construction.
REQ-024 The credit rule guarantees space for every response; if a response arrives with the queue full, the block SHALL assert a simulation assertion and drop the response.
REQ-025 On redirect_i: the queue flushes, fetch_pc becomes {redirect_pc_i[31:2],2'b00}, and every outstanding request, including one accepted in the same cycle, is counted in discard_cnt.
REQ-026 A response arriving while discard_cnt > 0 SHALL decrement discard_cnt and SHALL NOT be pushed; this includes a response in the redirect cycle itself.
REQ-027 On the cycle after a redirect, instr_valid_o SHALL be 0; a pop in the redirect cycle has no effect on the cleared state.
REQ-028 Requests to the new target MAY issue while discards are pending; ordering is preserved by the in-order response stream.
REQ-029 outstanding SHALL be incremented on accept and decremented on each response, discarded or not.

Reset
REQ-030 While reset_i = 0: req_valid_o = 0, instr_valid_o = 0, instr_o = 0, pc_o = 0, occupancy = 0, outstanding = 0, discard_cnt = 0, fetch_pc = RESET_VECTOR.
REQ-031 req_valid_o SHALL first rise in the first cycle after reset_i deasserts, with req_addr_o = RESET_VECTOR.
REQ-032 Reset asserted mid-operation SHALL abandon all in-flight requests; responses arriving afterwards are the memory's responsibility to suppress.

Structure
REQ-033 RESET_VECTOR default, word/address widths and the NOP encoding 32'h0000_0013 SHALL live in the shared CPU package.
REQ-034 The queue storage SHALL be a sub-module, sync_fifo (entries of {pc, instr}, with flush); request, credit and discard logic SHALL sit in the top level.

Verification
REQ-035 Reset release, memory always ready with 1-cycle response, instr_ready_i=1 -> pc_o sequence 0,4,8,12… and one instruction per cycle after a 3-cycle startup.
REQ-036 instr_ready_i=0 held -> exactly DEPTH=4 requests issued, then req_valid_o=0 and the queue holds PCs 0..12; release -> pops resume in order with no gaps.
REQ-037 Two requests outstanding (PCs 0x10, 0x14), redirect to 0x200 -> both responses dropped; the next instr_valid_o shows pc_o=0x200.
REQ-038 Redirect in the same cycle as a pop and a response -> queue empty next cycle; no stale PC ever appears.
REQ-039 req_ready_i stalled 5 cycles -> req_addr_o stable; redirect_pc_i=0x203 -> fetch address 0x200.
REQ-040 reset_i asserted while the queue holds 3 entries -> outputs zero asynchronously; after release, fetch restarts at RESET_VECTOR.
